// File: rtl/bmem_pkg.sv
// bmem_pkg: shared types and constants for the bmem burst-memory responder
package bmem_pkg;
  localparam int BMEM_BEATS = 4;
  localparam int BMEM_LINE_BYTES = 32;
  typedef enum logic [1:0] {IDLE, WRBURST, WAIT, BURST} bmem_state_t;
  typedef logic [63:0] bmem_word_t;
endpackage

// File: rtl/bmem_req_fifo.sv
// bmem_req_fifo: synchronous FIFO of queued read line addresses
module bmem_req_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW:0] wp, rp;
  assign empty = wp == rp;
  assign full = wp == {~rp[AW], rp[AW-1:0]};
  assign head = mem[rp[AW-1:0]];
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
    end
  end
  always_ff @(posedge clk)
    if (push) mem[wp[AW-1:0]] <= din;
endmodule

// File: rtl/bmem_responder.sv
// bmem_responder: memory side of bmem, backing array with queued latency-delayed read bursts
module bmem_responder
  import bmem_pkg::*;
#(
  parameter int MEM_ADDR_W = 14,
  parameter int LATENCY = 8,
  parameter int QDEPTH = 4,
  parameter string MEM_INIT = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] bmem_addr,
  input  logic        bmem_read,
  input  logic        bmem_write,
  input  logic [63:0] bmem_wdata,
  output logic        bmem_ready,
  output logic [63:0] bmem_rdata,
  output logic        bmem_resp,
  output logic        error
);
  localparam int LSB = $clog2(BMEM_LINE_BYTES);
  localparam int LW = MEM_ADDR_W - 2;
  localparam logic [1:0] LAST = 2'(BMEM_BEATS - 1);
  bmem_state_t state, state_n;
  logic [7:0] cnt, cnt_n;
  logic [1:0] beat, beat_n;
  logic [LW-1:0] line, line_n, req_line, head;
  logic full, empty, push, pop, wr_acc, wr_en, err_n, unused_addr;
  logic [MEM_ADDR_W-1:0] wr_idx;
  bmem_word_t mem [2**MEM_ADDR_W];
  // only the line bits that index the array are kept; the rest wrap away
  assign req_line = bmem_addr[LSB+LW-1:LSB];
  assign unused_addr = ^{bmem_addr[31:LSB+LW], bmem_addr[LSB-1:0]};
  assign bmem_ready = state != WRBURST && ((empty && state == IDLE) || !full);
  assign push = bmem_read && !bmem_write && bmem_ready;
  assign wr_acc = bmem_write && !bmem_read && state == IDLE && empty;
  assign pop = state == IDLE && !empty;
  bmem_req_fifo #(.DEPTH(QDEPTH), .W(LW)) u_fifo (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .din(req_line),
    .full(full), .empty(empty), .head(head)
  );
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    beat_n = beat;
    line_n = line;
    wr_en = 1'b0;
    wr_idx = {line, beat};
    err_n = (bmem_read && (bmem_write || !bmem_ready))
         || (bmem_write && state != WRBURST && !wr_acc)
         || (state == WRBURST && !bmem_write);
    unique case (state)
      IDLE: begin
        if (wr_acc) begin
          state_n = WRBURST;
          beat_n = 2'd1;
          line_n = req_line;
          wr_en = 1'b1;
          wr_idx = {req_line, 2'd0};
        end else if (pop) begin
          state_n = LATENCY == 1 ? BURST : WAIT;
          cnt_n = 8'(LATENCY - 1);
          beat_n = 2'd0;
          line_n = head;
        end
      end
      WRBURST: begin
        wr_en = bmem_write;
        beat_n = beat + 2'd1;
        state_n = (!bmem_write || beat == LAST) ? IDLE : WRBURST;
      end
      WAIT: begin
        cnt_n = cnt - 8'd1;
        state_n = cnt == 8'd1 ? BURST : WAIT;
      end
      BURST: begin
        beat_n = beat + 2'd1;
        state_n = beat == LAST ? IDLE : BURST;
      end
    endcase
  end
  // rdata is fetched with the next beat's index so it lands together with resp
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      beat <= '0;
      line <= '0;
      error <= 1'b0;
      bmem_resp <= 1'b0;
      bmem_rdata <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      beat <= beat_n;
      line <= line_n;
      error <= error | err_n;
      bmem_resp <= state_n == BURST;
      bmem_rdata <= state_n == BURST ? mem[{line_n, beat_n}] : '0;
    end
  end
  always_ff @(posedge clk)
    if (wr_en && !rst) mem[wr_idx] <= bmem_wdata;
endmodule
